// File: rtl/df_tile_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// df_tile_sequencer_pkg
// Shared types for the dataflow controller tile sequencer.
//   DF_ADDR_W   : default width of emitted tile offsets
//   seq_state_e : sequencer FSM states (IDLE, ISSUE, DONE)
//   tile_desc_t : one tile descriptor (three base offsets + reduction flags)
// ----------------------------------------------------------------------------
package df_tile_sequencer_pkg;

   localparam int DF_ADDR_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } seq_state_e;

   typedef struct packed {
      logic [DF_ADDR_W-1:0] psums_off;
      logic [DF_ADDR_W-1:0] ifmaps_off;
      logic [DF_ADDR_W-1:0] weights_off;
      logic                 first_c;
      logic                 last_c;
   } tile_desc_t;

endpackage

// File: rtl/df_loop_counter.sv
// ----------------------------------------------------------------------------
// df_loop_counter
// One level of the tile loop nest. Advances when carry_i is high; wraps to 0
// after reaching lim_i and then propagates the carry to the next outer loop.
//   clk_i, rstn_i : clock, synchronous active-low reset
//   clear_i       : force index to 0 (new run)
//   carry_i       : advance request from inner loop (or handshake for c)
//   lim_i         : last index (count-1)
//   idx_o         : current index
//   wrap_o        : index is at its limit
//   carry_o       : this loop wraps on the current advance
// ----------------------------------------------------------------------------
module df_loop_counter #(
   parameter int IDX_W = 12
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             clear_i,
   input  logic             carry_i,
   input  logic [IDX_W-1:0] lim_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             wrap_o,
   output logic             carry_o
);

   logic [IDX_W-1:0] idx_q, idx_d;

   assign wrap_o  = (idx_q == lim_i);
   assign carry_o = carry_i & wrap_o;
   assign idx_o   = idx_q;

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      idx_d = idx_q;
      if (clear_i)      idx_d = '0;
      else if (carry_i) idx_d = wrap_o ? '0 : idx_q + IDX_W'(1);
   end

   // NOTE: state registers use non-blocking assignments only.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) idx_q <= '0;
      else         idx_q <= idx_d;
   end

endmodule

// File: rtl/df_tile_sequencer.sv
// ----------------------------------------------------------------------------
// df_tile_sequencer
// Walks the k/y/x/c tile loop nest (c innermost) of one convolution layer and
// emits a descriptor per tile over a valid/ready handshake.
//   i_clk, i_rstn        : clock, synchronous active-low reset
//   i_start              : start pulse, honoured only in IDLE
//   i_{x,y,k,c}_lim      : last index of each loop
//   i_p_*/i_i_*/i_w_*    : per-loop address steps for psums, ifmaps, weights
//   o_busy               : start acceptance through done pulse
//   o_tile_valid/i_tile_ready : descriptor handshake
//   o_*_off, o_first_c, o_last_c : tile descriptor
//   o_tile_idx           : {k,y,x,c} current indices
//   o_done               : one-cycle pulse after the last handshake
// Offsets are running sums: an advancing loop adds its step, wrapping loops
// subtract the contribution they accumulated (kept in partial registers).
// ----------------------------------------------------------------------------
module df_tile_sequencer
   import df_tile_sequencer_pkg::*;
#(
   parameter int ADDR_W = DF_ADDR_W,
   parameter int IDX_W  = 12,
   parameter int STEP_W = 24
) (
   input  logic               i_clk,
   input  logic               i_rstn,
   input  logic               i_start,
   input  logic [IDX_W-1:0]   i_x_lim,
   input  logic [IDX_W-1:0]   i_y_lim,
   input  logic [IDX_W-1:0]   i_k_lim,
   input  logic [IDX_W-1:0]   i_c_lim,
   input  logic [STEP_W-1:0]  i_p_x_step,
   input  logic [STEP_W-1:0]  i_p_y_step,
   input  logic [STEP_W-1:0]  i_p_k_step,
   input  logic [STEP_W-1:0]  i_i_x_step,
   input  logic [STEP_W-1:0]  i_i_y_step,
   input  logic [STEP_W-1:0]  i_i_c_step,
   input  logic [STEP_W-1:0]  i_w_k_step,
   input  logic [STEP_W-1:0]  i_w_c_step,
   output logic               o_busy,
   output logic               o_tile_valid,
   input  logic               i_tile_ready,
   output logic [ADDR_W-1:0]  o_psums_off,
   output logic [ADDR_W-1:0]  o_ifmaps_off,
   output logic [ADDR_W-1:0]  o_weights_off,
   output logic               o_first_c,
   output logic               o_last_c,
   output logic [4*IDX_W-1:0] o_tile_idx,
   output logic               o_done
);

   seq_state_e state_q, state_d;

   // Latched configuration
   logic [IDX_W-1:0]  x_lim_q, y_lim_q, k_lim_q, c_lim_q;
   logic [STEP_W-1:0] p_x_q, p_y_q, p_k_q, i_x_q, i_y_q, i_c_q, w_k_q, w_c_q;

   // Offset accumulators and per-loop partial contributions
   logic [ADDR_W-1:0] psums_q, psums_d, ifmaps_q, ifmaps_d, weights_q, weights_d;
   logic [ADDR_W-1:0] pp_x_q, pp_x_d, pp_y_q, pp_y_d, pp_k_q, pp_k_d;
   logic [ADDR_W-1:0] ip_x_q, ip_x_d, ip_y_q, ip_y_d, ip_c_q, ip_c_d;
   logic [ADDR_W-1:0] wp_k_q, wp_k_d, wp_c_q, wp_c_d;

   logic [IDX_W-1:0] c_idx, x_idx, y_idx, k_idx;
   logic             c_wrap, x_wrap, y_wrap, k_wrap;
   logic             c_carry, x_carry, y_carry, k_carry;
   logic             start_acc, fire;
   logic             inc_c, inc_x, inc_y, inc_k, wrp_c, wrp_x, wrp_y, wrp_k;

   assign start_acc = (state_q == IDLE) && i_start;
   assign fire      = (state_q == ISSUE) && i_tile_ready;

   // A loop advances when it receives a carry and is not at its limit;
   // it wraps when it receives a carry at its limit.
   assign inc_c = fire    & ~c_wrap;
   assign wrp_c = fire    &  c_wrap;
   assign inc_x = c_carry & ~x_wrap;
   assign wrp_x = c_carry &  x_wrap;
   assign inc_y = x_carry & ~y_wrap;
   assign wrp_y = x_carry &  y_wrap;
   assign inc_k = y_carry & ~k_wrap;
   assign wrp_k = y_carry &  k_wrap;

   df_loop_counter #(.IDX_W(IDX_W)) u_c (.clk_i(i_clk), .rstn_i(i_rstn), .clear_i(start_acc),
      .carry_i(fire),    .lim_i(c_lim_q), .idx_o(c_idx), .wrap_o(c_wrap), .carry_o(c_carry));
   df_loop_counter #(.IDX_W(IDX_W)) u_x (.clk_i(i_clk), .rstn_i(i_rstn), .clear_i(start_acc),
      .carry_i(c_carry), .lim_i(x_lim_q), .idx_o(x_idx), .wrap_o(x_wrap), .carry_o(x_carry));
   df_loop_counter #(.IDX_W(IDX_W)) u_y (.clk_i(i_clk), .rstn_i(i_rstn), .clear_i(start_acc),
      .carry_i(x_carry), .lim_i(y_lim_q), .idx_o(y_idx), .wrap_o(y_wrap), .carry_o(y_carry));
   df_loop_counter #(.IDX_W(IDX_W)) u_k (.clk_i(i_clk), .rstn_i(i_rstn), .clear_i(start_acc),
      .carry_i(y_carry), .lim_i(k_lim_q), .idx_o(k_idx), .wrap_o(k_wrap), .carry_o(k_carry));

   function automatic logic [ADDR_W-1:0] sel(input logic en, input logic [STEP_W-1:0] v);
      return en ? ADDR_W'(v) : '0;
   endfunction

   function automatic logic [ADDR_W-1:0] part_nxt(input logic [ADDR_W-1:0] part,
                                                  input logic [STEP_W-1:0] step,
                                                  input logic inc, input logic wrp);
      return wrp ? '0 : (inc ? part + ADDR_W'(step) : part);
   endfunction

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (i_start) state_d = ISSUE;
         ISSUE:   if (k_carry) state_d = DONE;   // handshake of the last tile
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      psums_d   = psums_q + sel(inc_x, p_x_q) + sel(inc_y, p_y_q) + sel(inc_k, p_k_q)
                  - (wrp_x ? pp_x_q : '0) - (wrp_y ? pp_y_q : '0) - (wrp_k ? pp_k_q : '0);
      ifmaps_d  = ifmaps_q + sel(inc_x, i_x_q) + sel(inc_y, i_y_q) + sel(inc_c, i_c_q)
                  - (wrp_x ? ip_x_q : '0) - (wrp_y ? ip_y_q : '0) - (wrp_c ? ip_c_q : '0);
      weights_d = weights_q + sel(inc_k, w_k_q) + sel(inc_c, w_c_q)
                  - (wrp_k ? wp_k_q : '0) - (wrp_c ? wp_c_q : '0);
      pp_x_d = part_nxt(pp_x_q, p_x_q, inc_x, wrp_x);
      pp_y_d = part_nxt(pp_y_q, p_y_q, inc_y, wrp_y);
      pp_k_d = part_nxt(pp_k_q, p_k_q, inc_k, wrp_k);
      ip_x_d = part_nxt(ip_x_q, i_x_q, inc_x, wrp_x);
      ip_y_d = part_nxt(ip_y_q, i_y_q, inc_y, wrp_y);
      ip_c_d = part_nxt(ip_c_q, i_c_q, inc_c, wrp_c);
      wp_k_d = part_nxt(wp_k_q, w_k_q, inc_k, wrp_k);
      wp_c_d = part_nxt(wp_c_q, w_c_q, inc_c, wrp_c);
      if (start_acc) begin
         psums_d = '0; ifmaps_d = '0; weights_d = '0;
         pp_x_d  = '0; pp_y_d   = '0; pp_k_d    = '0;
         ip_x_d  = '0; ip_y_d   = '0; ip_c_d    = '0;
         wp_k_d  = '0; wp_c_d   = '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state_q <= IDLE;
         psums_q <= '0; ifmaps_q <= '0; weights_q <= '0;
         pp_x_q  <= '0; pp_y_q   <= '0; pp_k_q    <= '0;
         ip_x_q  <= '0; ip_y_q   <= '0; ip_c_q    <= '0;
         wp_k_q  <= '0; wp_c_q   <= '0;
      end else begin
         state_q <= state_d;
         psums_q <= psums_d; ifmaps_q <= ifmaps_d; weights_q <= weights_d;
         pp_x_q  <= pp_x_d;  pp_y_q   <= pp_y_d;   pp_k_q    <= pp_k_d;
         ip_x_q  <= ip_x_d;  ip_y_q   <= ip_y_d;   ip_c_q    <= ip_c_d;
         wp_k_q  <= wp_k_d;  wp_c_q   <= wp_c_d;
      end
   end

   // Configuration is captured only on the accepting edge.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         x_lim_q <= '0; y_lim_q <= '0; k_lim_q <= '0; c_lim_q <= '0;
         p_x_q <= '0; p_y_q <= '0; p_k_q <= '0;
         i_x_q <= '0; i_y_q <= '0; i_c_q <= '0;
         w_k_q <= '0; w_c_q <= '0;
      end else if (start_acc) begin
         x_lim_q <= i_x_lim; y_lim_q <= i_y_lim; k_lim_q <= i_k_lim; c_lim_q <= i_c_lim;
         p_x_q <= i_p_x_step; p_y_q <= i_p_y_step; p_k_q <= i_p_k_step;
         i_x_q <= i_i_x_step; i_y_q <= i_i_y_step; i_c_q <= i_i_c_step;
         w_k_q <= i_w_k_step; w_c_q <= i_w_c_step;
      end
   end

   assign o_busy        = (state_q != IDLE);
   assign o_tile_valid  = (state_q == ISSUE);
   assign o_done        = (state_q == DONE);
   assign o_psums_off   = psums_q;
   assign o_ifmaps_off  = ifmaps_q;
   assign o_weights_off = weights_q;
   // Flags are qualified by valid so they read 0 outside ISSUE.
   assign o_first_c     = o_tile_valid && (c_idx == '0);
   assign o_last_c      = o_tile_valid && c_wrap;
   assign o_tile_idx    = {k_idx, y_idx, x_idx, c_idx};

endmodule

// File: tb/tb_df_tile_sequencer.sv
// ----------------------------------------------------------------------------
// tb_df_tile_sequencer
// Directed bench for df_tile_sequencer: expected descriptors are kept in a
// table and compared tile by tile as the handshake advances.
// ----------------------------------------------------------------------------
module tb_df_tile_sequencer;
   import df_tile_sequencer_pkg::*;

   localparam int ADDR_W = 32;
   localparam int IDX_W  = 12;
   localparam int STEP_W = 24;

   logic               i_clk = 1'b0;
   logic               i_rstn, i_start, i_tile_ready;
   logic [IDX_W-1:0]   i_x_lim, i_y_lim, i_k_lim, i_c_lim;
   logic [STEP_W-1:0]  i_p_x_step, i_p_y_step, i_p_k_step;
   logic [STEP_W-1:0]  i_i_x_step, i_i_y_step, i_i_c_step;
   logic [STEP_W-1:0]  i_w_k_step, i_w_c_step;
   logic               o_busy, o_tile_valid, o_first_c, o_last_c, o_done;
   logic [ADDR_W-1:0]  o_psums_off, o_ifmaps_off, o_weights_off;
   logic [4*IDX_W-1:0] o_tile_idx;

   df_tile_sequencer #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .STEP_W(STEP_W)) dut (
      .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start),
      .i_x_lim(i_x_lim), .i_y_lim(i_y_lim), .i_k_lim(i_k_lim), .i_c_lim(i_c_lim),
      .i_p_x_step(i_p_x_step), .i_p_y_step(i_p_y_step), .i_p_k_step(i_p_k_step),
      .i_i_x_step(i_i_x_step), .i_i_y_step(i_i_y_step), .i_i_c_step(i_i_c_step),
      .i_w_k_step(i_w_k_step), .i_w_c_step(i_w_c_step),
      .o_busy(o_busy), .o_tile_valid(o_tile_valid), .i_tile_ready(i_tile_ready),
      .o_psums_off(o_psums_off), .o_ifmaps_off(o_ifmaps_off), .o_weights_off(o_weights_off),
      .o_first_c(o_first_c), .o_last_c(o_last_c), .o_tile_idx(o_tile_idx), .o_done(o_done)
   );

   always #5 i_clk = ~i_clk;

   typedef struct packed {
      tile_desc_t        d;
      logic [4*IDX_W-1:0] idx;
   } exp_t;

   exp_t exp_tab[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   function automatic exp_t mk(input int ps, input int ifm, input int wt,
                               input int k, input int y, input int x, input int c,
                               input logic first, input logic last);
      exp_t e;
      e.d.psums_off   = ps;
      e.d.ifmaps_off  = ifm;
      e.d.weights_off = wt;
      e.d.first_c     = first;
      e.d.last_c      = last;
      e.idx           = {IDX_W'(k), IDX_W'(y), IDX_W'(x), IDX_W'(c)};
      return e;
   endfunction

   task automatic set_cfg(input int xl, input int yl, input int kl, input int cl,
                          input int px, input int py, input int pk,
                          input int ix, input int iy, input int ic,
                          input int wk, input int wc);
      i_x_lim = IDX_W'(xl); i_y_lim = IDX_W'(yl); i_k_lim = IDX_W'(kl); i_c_lim = IDX_W'(cl);
      i_p_x_step = STEP_W'(px); i_p_y_step = STEP_W'(py); i_p_k_step = STEP_W'(pk);
      i_i_x_step = STEP_W'(ix); i_i_y_step = STEP_W'(iy); i_i_c_step = STEP_W'(ic);
      i_w_k_step = STEP_W'(wk); i_w_c_step = STEP_W'(wc);
   endtask

   task automatic do_start();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
   endtask

   // Case 2 configuration and its hand-computed tile table.
   task automatic load_case2();
      set_cfg(1, 0, 0, 2, 8, 'h777, 'h555, 'h10, 'h333, 'h100, 'h999, 4);
      exp_tab.delete();
      exp_tab.push_back(mk('h0,  'h000, 0, 0, 0, 0, 0, 1'b1, 1'b0));
      exp_tab.push_back(mk('h0,  'h100, 4, 0, 0, 0, 1, 1'b0, 1'b0));
      exp_tab.push_back(mk('h0,  'h200, 8, 0, 0, 0, 2, 1'b0, 1'b1));
      exp_tab.push_back(mk('h8,  'h010, 0, 0, 0, 1, 0, 1'b1, 1'b0));
      exp_tab.push_back(mk('h8,  'h110, 4, 0, 0, 1, 1, 1'b0, 1'b0));
      exp_tab.push_back(mk('h8,  'h210, 8, 0, 0, 1, 2, 1'b0, 1'b1));
   endtask

   // mode 0: ready always high; mode 1: ready high one cycle in three;
   // mode 2: ready high with i_start and config inputs scrambled throughout.
   task automatic run_tiles(input string tag, input int mode);
      int n   = exp_tab.size();
      int got = 0;
      int cyc = 0;
      while (got < n && cyc < 400) begin
         i_tile_ready = (mode == 1) ? ((cyc % 3) == 2) : 1'b1;
         if (mode == 2) begin
            i_start = 1'b1;
            set_cfg($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom);
         end
         check({tag, " valid"}, 64'(o_tile_valid), 64'd1);
         check({tag, " busy"},  64'(o_busy),       64'd1);
         check({tag, " psums"}, 64'(o_psums_off),  64'(exp_tab[got].d.psums_off));
         check({tag, " ifmaps"}, 64'(o_ifmaps_off), 64'(exp_tab[got].d.ifmaps_off));
         check({tag, " weights"}, 64'(o_weights_off), 64'(exp_tab[got].d.weights_off));
         check({tag, " flags"}, 64'({o_first_c, o_last_c}),
               64'({exp_tab[got].d.first_c, exp_tab[got].d.last_c}));
         check({tag, " idx"},   64'(o_tile_idx),   64'(exp_tab[got].idx));
         check({tag, " early done"}, 64'(o_done),  64'd0);
         if (i_tile_ready) got++;
         tick();
         cyc++;
      end
      check({tag, " tiles seen"}, 64'(got), 64'(n));
      if (mode != 1) check({tag, " throughput"}, 64'(cyc), 64'(n));
      i_tile_ready = 1'b0;
      check({tag, " done pulse"}, 64'(o_done), 64'd1);
      check({tag, " busy in done"}, 64'(o_busy), 64'd1);
      check({tag, " valid in done"}, 64'(o_tile_valid), 64'd0);
      tick();
      i_start = 1'b0;
      check({tag, " done low"}, 64'(o_done), 64'd0);
      check({tag, " idle busy"}, 64'(o_busy), 64'd0);
      check({tag, " idle valid"}, 64'(o_tile_valid), 64'd0);
      tick();
      check({tag, " stays idle"}, 64'(o_busy), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      i_rstn = 1'b0; i_start = 1'b0; i_tile_ready = 1'b0;
      set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(); tick();
      check("rst busy",  64'(o_busy), 64'd0);
      check("rst valid", 64'(o_tile_valid), 64'd0);
      check("rst done",  64'(o_done), 64'd0);
      check("rst offs",  64'(o_psums_off | o_ifmaps_off | o_weights_off), 64'd0);
      check("rst flags", 64'({o_first_c, o_last_c}), 64'd0);
      check("rst idx",   64'(o_tile_idx), 64'd0);
      i_rstn = 1'b1;
      tick();

      // Single tile with all limits zero.
      set_cfg(0, 0, 0, 0, 'h12, 'h34, 'h56, 'h78, 'h9a, 'hbc, 'hde, 'hf0);
      exp_tab.delete();
      exp_tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1));
      do_start();
      run_tiles("single", 0);

      // Two-loop walk, ready always high.
      load_case2();
      do_start();
      run_tiles("c2", 0);

      // Same walk under backpressure.
      load_case2();
      do_start();
      run_tiles("c2bp", 1);

      // Full nest against a product-sum model.
      begin
         int px = 'h3, py = 'h50, pk = 'h700, ix = 'h11, iy = 'h220, ic = 'h3300;
         int wk = 'h40000, wc = 'h5;
         set_cfg(1, 1, 1, 1, px, py, pk, ix, iy, ic, wk, wc);
         exp_tab.delete();
         for (int k = 0; k < 2; k++)
            for (int y = 0; y < 2; y++)
               for (int x = 0; x < 2; x++)
                  for (int c = 0; c < 2; c++)
                     exp_tab.push_back(mk(x*px + y*py + k*pk, x*ix + y*iy + c*ic,
                                          k*wk + c*wc, k, y, x, c, c == 0, c == 1));
         do_start();
         run_tiles("full", 0);
      end

      // Start pulses and config changes during a run are ignored.
      load_case2();
      do_start();
      run_tiles("ignore", 2);

      // Reset while tile 3 is presented, then a clean rerun.
      load_case2();
      do_start();
      i_tile_ready = 1'b1;
      tick(); tick(); tick();
      check("pre-rst idx", 64'(o_tile_idx), 64'(exp_tab[3].idx));
      i_rstn = 1'b0;
      tick();
      check("midrst valid", 64'(o_tile_valid), 64'd0);
      check("midrst busy",  64'(o_busy), 64'd0);
      check("midrst offs",  64'(o_psums_off | o_ifmaps_off | o_weights_off), 64'd0);
      check("midrst idx",   64'(o_tile_idx), 64'd0);
      i_rstn = 1'b1;
      i_tile_ready = 1'b0;
      tick();
      do_start();
      run_tiles("rerun", 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
